// File: rtl/logic_unit_n.sv
// Registered N-bit bitwise logic unit with an accumulator and a one-entry valid/ready output stage.
// Define LOGIC_UNIT_FLAGS_EN to register zero/parity flags alongside the result.
module logic_unit_n #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    input  logic         acc_sel,
    input  logic         acc_wr,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic [N-1:0] acc,
    output logic         zero,
    output logic         parity
);

    logic         accept;
    logic [N-1:0] op_a;
    logic [N-1:0] result;

    // The output register is free when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op_a     = acc_sel ? acc : a;

    always_comb begin
        result = '0;
        case (op)
            3'b000:  result = op_a & b;
            3'b001:  result = op_a | b;
            3'b010:  result = op_a ^ b;
            3'b011:  result = ~(op_a & b);
            3'b100:  result = ~(op_a | b);
            3'b101:  result = ~(op_a ^ b);
            3'b110:  result = ~op_a;
            default: result = op_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            s         <= result;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins over write; operand A above already saw the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (accept && acc_wr) begin
            acc <= result;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero   <= 1'b0;
            parity <= 1'b0;
        end else if (accept) begin
            zero   <= (result == '0);
            parity <= ^result;
        end
    end
`else
    assign zero   = 1'b0;
    assign parity = 1'b0;
`endif

endmodule

// File: doc/logic_unit_n.md
LOGIC_UNIT_N -- requirements
Module: logic_unit_n

Interface
REQ-001 SHALL provide parameter N, default 4, operand/result width in bits (N >= 1).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port in_valid  input  1  operation request valid.
REQ-005 SHALL provide port in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL provide ports a, b  input  N each  operands.
REQ-007 SHALL provide port op  input  3  operation select.
REQ-008 SHALL provide port acc_sel  input  1  use accumulator instead of a as operand A.
REQ-009 SHALL provide port acc_wr  input  1  write result into accumulator on accept.
REQ-010 SHALL provide port acc_clr  input  1  clear accumulator.
REQ-011 SHALL provide port out_valid  output  1  result s valid.
REQ-012 SHALL provide port out_ready  input  1  downstream accepts result.
REQ-013 SHALL provide port s  output  N  registered result.
REQ-014 SHALL provide port acc  output  N  current accumulator value.
REQ-015 SHALL provide ports zero, parity  output  1 each  result flags.

Function
REQ-016 SHALL accept a request when in_valid && in_ready at a clock edge ("accept").
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational; one-entry output register, full throughput).
REQ-018 SHALL compute bitwise on operand A (acc if acc_sel else a) and b: op 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 pass A.
REQ-019 SHALL register the result into s and set out_valid on the edge of accept; latency exactly 1 cycle.
REQ-020 SHALL hold s, out_valid, zero, parity stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on an edge with out_valid && out_ready and no accept; simultaneous drain and accept SHALL load the new result with out_valid staying 1.
REQ-022 SHALL, on accept with acc_wr=1, load the result into acc on the same edge.
REQ-023 SHALL, when acc_clr=1, clear acc to 0 on the edge regardless of in_valid; acc_clr SHALL override acc_wr in the same cycle.
REQ-024 SHALL use the pre-edge acc value as operand A when acc_sel, acc_clr and accept coincide.
REQ-025 SHALL ignore a, b, op, acc_sel, acc_wr when no accept occurs.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force s=0, acc=0, out_valid=0, zero=0, parity=0.
REQ-027 SHALL drop any pending result when reset asserts mid-operation; first accept possible on the first edge after rst_n rises.
REQ-028 SHALL drive in_ready=1 during and immediately after reset.

Configuration
REQ-029 SHALL, with macro LOGIC_UNIT_FLAGS_EN defined, register zero = (result == 0) and parity = XOR-reduction of result alongside s.
REQ-030 SHALL, without LOGIC_UNIT_FLAGS_EN, tie zero and parity to constant 0 with no flag logic generated; all other behaviour unchanged.

Verification
REQ-031 SHALL cover: N=4, a=1100, b=1010, op sweep 000..111, out_ready=1 -> s = 1000,1110,0110,0111,0001,1001,0011,1100 each 1 cycle after accept.
REQ-032 SHALL cover: out_ready=0 for 3 cycles after result 1000 -> in_ready=0, s held 1000; out_ready=1 with new request same cycle -> next result loads, no bubble, no loss.
REQ-033 SHALL cover: acc_clr, then accepts acc_sel=1, acc_wr=1, op=001 with b=0001,0100,1000 -> acc = 0001, 0101, 1101.
REQ-034 SHALL cover: acc_clr=1 and acc_wr=1 with accept in same cycle, acc=0110 -> acc=0000, s = f(0110, b).
REQ-035 SHALL cover: rst_n pulsed low between edges while out_valid=1 -> out_valid, s, acc immediately 0; flags 0.
REQ-036 SHALL cover: with LOGIC_UNIT_FLAGS_EN, a=1010, b=0101, op=000 -> zero=1, parity=0; op=001 -> zero=0, parity=0; op=110 (NOT A) on 1011 -> s=0100, parity=1; without macro zero=parity=0 throughout.
